// File: rtl/change_dispense_module_pkg.sv
// rtl/change_dispense_module_pkg.sv - shared types and constants for the change dispenser
// Purpose: state encoding, BCD digit width, coin values and balance field positions,
//          shared with the coin-accumulation logic.
// Ports: none (package).
package change_dispense_module_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CHECK,
    ST_REQ,
    ST_WAIT_ACK,
    ST_WAIT_REL,
    ST_FIN,
    ST_ERR
  } state_t;

  localparam int DIGIT_W = 4;
  localparam int BAL_W   = 24;

  // Balance field LSB positions: [15:12] tens of yuan, [11:8] yuan, [7:4] jiao.
  localparam int TENS_LSB = 12;
  localparam int YUAN_LSB = 8;
  localparam int JIAO_LSB = 4;

  // Coin values expressed in the digit they are taken from.
  localparam logic [DIGIT_W-1:0] COIN_1Y_YUAN = 4'd1;
  localparam logic [DIGIT_W-1:0] COIN_5J_JIAO = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_MAX      = 4'd9;

  function automatic logic bcd_ok(input logic [DIGIT_W-1:0] d);
    return d <= BCD_MAX;
  endfunction

endpackage

// File: rtl/change_dispense_module_if.sv
// rtl/change_dispense_module_if.sv - request/payout bus of the change dispenser
// Purpose: bundles the payout request, dispenser handshake and status signals.
// Ports (master drives / slave receives):
//   start, balance_in, coin_ack          master -> slave
//   req_1y, req_5j, busy, done, err,
//   remain                               slave -> master
interface change_dispense_module_if;
  import change_dispense_module_pkg::*;

  logic             start;
  logic [BAL_W-1:0] balance_in;
  logic             coin_ack;
  logic             req_1y;
  logic             req_5j;
  logic             busy;
  logic             done;
  logic             err;
  logic [BAL_W-1:0] remain;

  modport master (
    output start, balance_in, coin_ack,
    input  req_1y, req_5j, busy, done, err, remain
  );

  modport slave (
    input  start, balance_in, coin_ack,
    output req_1y, req_5j, busy, done, err, remain
  );

endinterface

// File: rtl/change_ack_timer.sv
// rtl/change_ack_timer.sv - watchdog counter for the coin acknowledge handshake
// Purpose: counts cycles spent in a wait state; expired is high in the LIMIT-th cycle.
// Ports: CLK, RSTn (async active-low), restart (first cycle of a new wait state),
//        run (currently in a wait state), expired (limit reached this cycle).
module change_ack_timer #(
  parameter logic [15:0] LIMIT = 16'd50000
) (
  input  logic CLK,
  input  logic RSTn,
  input  logic restart,
  input  logic run,
  output logic expired
);

  logic [15:0] cnt;
  logic [15:0] cnt_now;

  // Cycles already spent in the current wait state, not counting this one.
  assign cnt_now = restart ? 16'd0 : cnt;
  assign expired = run && (cnt_now == LIMIT - 16'd1);

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt_now + 16'd1;
    end
  end

endmodule

// File: rtl/change_dispense_module.sv
// rtl/change_dispense_module.sv - BCD balance payout controller (1-yuan then 5-jiao coins)
// Purpose: latches a BCD balance, pays it out coin by coin over a level req/ack
//          handshake and reports completion, errors and the undispensed remainder.
// Ports: CLK, RSTn (async active-low),
//        bus (change_dispense_module_if.slave): start, balance_in, coin_ack in;
//        req_1y, req_5j, busy, done, err, remain out.
// Option: CHANGE_TIMEOUT_EN adds an ACK_TIMEOUT-cycle watchdog (change_ack_timer)
//         on the WAIT_ACK and WAIT_REL states.
module change_dispense_module
  import change_dispense_module_pkg::*;
#(
  parameter logic [15:0] ACK_TIMEOUT = 16'd50000
) (
  input logic CLK,
  input logic RSTn,
  change_dispense_module_if.slave bus
);

  state_t             state;
  logic [DIGIT_W-1:0] tens;
  logic [DIGIT_W-1:0] yuan;
  logic [DIGIT_W-1:0] jiao;
  logic               coin_1y;
  logic               req_1y_q;
  logic               req_5j_q;
  logic               busy_q;
  logic               done_q;
  logic               err_q;
  logic               tmo;
  logic               unused_bal_bits;

  assign unused_bal_bits = ^{bus.balance_in[BAL_W-1:TENS_LSB+DIGIT_W],
                             bus.balance_in[JIAO_LSB-1:0]};

`ifdef CHANGE_TIMEOUT_EN
  logic tmr_restart;
  logic tmr_run;

  assign tmr_run = (state == ST_WAIT_ACK) || (state == ST_WAIT_REL);

  change_ack_timer #(
    .LIMIT(ACK_TIMEOUT)
  ) u_ack_timer (
    .CLK     (CLK),
    .RSTn    (RSTn),
    .restart (tmr_restart),
    .run     (tmr_run),
    .expired (tmo)
  );
`else
  localparam logic [15:0] unused_ack_timeout = ACK_TIMEOUT;
  assign tmo = 1'b0;
`endif

  assign bus.req_1y = req_1y_q;
  assign bus.req_5j = req_5j_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;
  assign bus.remain = {8'h00, tens, yuan, jiao, 4'h0};

  // Outputs are registered on the transition into the state they belong to,
  // so done/err are visible during FIN/ERR and req_* during REQ/WAIT_ACK.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state    <= ST_IDLE;
      tens     <= '0;
      yuan     <= '0;
      jiao     <= '0;
      coin_1y  <= 1'b0;
      req_1y_q <= 1'b0;
      req_5j_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      tmr_restart <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef CHANGE_TIMEOUT_EN
      tmr_restart <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            tens   <= bus.balance_in[TENS_LSB +: DIGIT_W];
            yuan   <= bus.balance_in[YUAN_LSB +: DIGIT_W];
            jiao   <= bus.balance_in[JIAO_LSB +: DIGIT_W];
            err_q  <= 1'b0;
            busy_q <= 1'b1;
            state  <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (!bcd_ok(tens) || !bcd_ok(yuan) || !bcd_ok(jiao)) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_ERR;
          end else if ((tens != '0) || (yuan != '0)) begin
            coin_1y  <= 1'b1;
            req_1y_q <= 1'b1;
            state    <= ST_REQ;
          end else if (jiao >= COIN_5J_JIAO) begin
            coin_1y  <= 1'b0;
            req_5j_q <= 1'b1;
            state    <= ST_REQ;
          end else begin
            // A 1..4 jiao residual cannot be paid; it stays in remain.
            err_q  <= (jiao != '0);
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_FIN;
          end
        end
        ST_REQ: begin
          state <= ST_WAIT_ACK;
`ifdef CHANGE_TIMEOUT_EN
          tmr_restart <= 1'b1;
`endif
        end
        ST_WAIT_ACK: begin
          if (bus.coin_ack) begin
            req_1y_q <= 1'b0;
            req_5j_q <= 1'b0;
            if (coin_1y) begin
              if (yuan == '0) begin
                yuan <= BCD_MAX;
                tens <= tens - 4'd1;
              end else begin
                yuan <= yuan - COIN_1Y_YUAN;
              end
            end else begin
              jiao <= jiao - COIN_5J_JIAO;
            end
            state <= ST_WAIT_REL;
`ifdef CHANGE_TIMEOUT_EN
            tmr_restart <= 1'b1;
`endif
          end else if (tmo) begin
            req_1y_q <= 1'b0;
            req_5j_q <= 1'b0;
            err_q    <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state    <= ST_ERR;
          end
        end
        ST_WAIT_REL: begin
          if (!bus.coin_ack) begin
            state <= ST_CHECK;
          end else if (tmo) begin
            err_q  <= 1'b1;
            done_q <= 1'b1;
            busy_q <= 1'b0;
            state  <= ST_ERR;
          end
        end
        ST_FIN, ST_ERR: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispense_module.sv
// tb/tb_change_dispense_module.sv - self-checking bench for change_dispense_module
// Purpose: directed payouts against a jiao-arithmetic model checked every cycle.
// Ports: none (top-level bench). CHANGE_TIMEOUT_EN enables the watchdog scenario.
module tb_change_dispense_module;

  logic CLK  = 1'b0;
  logic RSTn = 1'b0;

  always #5 CLK = ~CLK;

  change_dispense_module_if bus ();

  change_dispense_module #(
    .ACK_TIMEOUT(16'd8)
  ) dut (
    .CLK  (CLK),
    .RSTn (RSTn),
    .bus  (bus)
  );

  int errors = 0;
  int checks = 0;

  // Model of the transaction in progress, in whole jiao.
  bit          in_txn        = 1'b0;
  bit          tmo_mode      = 1'b0;
  bit          ack_en        = 1'b1;
  bit          invalid_exp   = 1'b0;
  bit          exp_err_final = 1'b0;
  int          total_j       = 0;
  int          n1_exp        = 0;
  int          n5_exp        = 0;
  int          paid          = 0;
  int          paid_val      = 0;
  logic [23:0] inv_rem       = '0;
  logic        last_err      = 1'b0;
  logic [23:0] last_rem      = '0;
  bit          pin_en        = 1'b0;
  logic [23:0] pin_rem       = '0;

  // Dispenser responder and handshake tallies.
  int ack_wait    = 0;
  bit ack_counted = 1'b1;
  bit ack_type    = 1'b0;
  int seen1       = 0;
  int seen5       = 0;
  int dones       = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] to_bcd(input int v);
    logic [3:0] t, y, j;
    t = 4'(v / 100);
    y = 4'((v / 10) % 10);
    j = 4'(v % 10);
    return {8'h00, t, y, j, 4'h0};
  endfunction

  always @(negedge CLK) begin : model_cmp
    logic        counted;
    logic [23:0] exp_rem;
    int          ti, yi, ji;
    counted = 1'b0;
    if (!RSTn) begin
      in_txn      = 1'b0;
      last_err    = 1'b0;
      last_rem    = '0;
      bus.coin_ack = 1'b0;
      ack_wait    = 0;
      ack_counted = 1'b1;
      chk("rst_req_1y", bus.req_1y, 0);
      chk("rst_req_5j", bus.req_5j, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_err", bus.err, 0);
      chk("rst_remain", bus.remain, 0);
    end else begin
      // A coin is paid at the edge where our ack was first seen high.
      if (bus.coin_ack && !ack_counted && in_txn) begin
        ack_counted = 1'b1;
        counted     = 1'b1;
        paid_val   += (paid < n1_exp) ? 10 : 5;
        paid++;
        if (ack_type) seen5++;
        else          seen1++;
      end
      if (bus.start && !in_txn) begin
        ti = int'(bus.balance_in[15:12]);
        yi = int'(bus.balance_in[11:8]);
        ji = int'(bus.balance_in[7:4]);
        invalid_exp   = (ti > 9) || (yi > 9) || (ji > 9);
        total_j       = ti * 100 + yi * 10 + ji;
        n1_exp        = invalid_exp ? 0 : ti * 10 + yi;
        n5_exp        = (!invalid_exp && ji >= 5) ? 1 : 0;
        inv_rem       = {8'h00, bus.balance_in[15:4], 4'h0};
        exp_err_final = tmo_mode || invalid_exp || ((ji % 5) != 0);
        paid          = 0;
        paid_val      = 0;
        in_txn        = 1'b1;
      end
      if (in_txn) begin
        exp_rem = invalid_exp ? inv_rem : to_bcd(total_j - paid_val);
        chk("remain", bus.remain, exp_rem);
        chk("req_onehot", bus.req_1y & bus.req_5j, 0);
        if (counted) chk("req_drop_on_ack", bus.req_1y | bus.req_5j, 0);
        if (bus.req_1y | bus.req_5j) chk("req_kind_5j", bus.req_5j, paid >= n1_exp);
        if (counted && pin_en && paid == 1) chk("remain_first_coin", bus.remain, pin_rem);
        if (bus.done) begin
          chk("done_busy", bus.busy, 0);
          chk("done_err", bus.err, exp_err_final);
          chk("done_req", bus.req_1y | bus.req_5j, 0);
          chk("done_coins", paid, tmo_mode ? 0 : n1_exp + n5_exp);
          dones++;
          last_err = exp_err_final;
          last_rem = exp_rem;
          in_txn   = 1'b0;
        end else begin
          chk("busy", bus.busy, 1);
          chk("err_clear", bus.err, 0);
        end
      end else begin
        chk("idle_busy", bus.busy, 0);
        chk("idle_done", bus.done, 0);
        chk("idle_req", bus.req_1y | bus.req_5j, 0);
        chk("idle_err", bus.err, last_err);
        chk("idle_remain", bus.remain, last_rem);
      end
      // Dispenser: ack three cycles after a request, release when it drops.
      if (bus.coin_ack) begin
        if (!bus.req_1y && !bus.req_5j) bus.coin_ack = 1'b0;
      end else if (ack_en && (bus.req_1y || bus.req_5j)) begin
        ack_wait++;
        if (ack_wait == 3) begin
          bus.coin_ack = 1'b1;
          ack_wait     = 0;
          ack_counted  = 1'b0;
          ack_type     = bus.req_5j;
        end
      end else begin
        ack_wait = 0;
      end
    end
  end

  task automatic wait_done(input int budget, output int lat);
    lat = 0;
    while (!bus.done && lat < budget) begin
      @(negedge CLK);
      #1;
      lat++;
    end
  endtask

  task automatic launch(input logic [23:0] bal);
    @(negedge CLK);
    #1;
    seen1 = 0;
    seen5 = 0;
    dones = 0;
    bus.balance_in = bal;
    bus.start      = 1'b1;
    @(negedge CLK);
    #1;
    bus.start = 1'b0;
  endtask

  task automatic run_txn(input string name, input logic [23:0] bal, input int e1, input int e5,
                         input int elat, input logic eerr, input logic [23:0] erem);
    int lat;
    launch(bal);
    wait_done(4000, lat);
    chk({name, "_done_seen"}, bus.done, 1);
    if (elat > 0) chk({name, "_latency"}, lat + 1, elat);
    chk({name, "_n_1y"}, seen1, e1);
    chk({name, "_n_5j"}, seen5, e5);
    chk({name, "_err"}, bus.err, eerr);
    chk({name, "_remain"}, bus.remain, erem);
    chk({name, "_done_count"}, dones, 1);
    @(negedge CLK);
    #1;
    chk({name, "_done_pulse"}, bus.done, 0);
    chk({name, "_busy_after"}, bus.busy, 0);
  endtask

  initial begin
    int lat;
    bus.start      = 1'b0;
    bus.balance_in = '0;
    repeat (2) @(negedge CLK);
    #1;
    chk("reset_busy", bus.busy, 0);
    chk("reset_remain", bus.remain, 24'h000000);
    RSTn = 1'b1;

    pin_en  = 1'b1;
    pin_rem = 24'h001150;
    run_txn("pay_12y5", 24'h001250, 12, 1, -1, 1'b0, 24'h000000);
    pin_rem = 24'h000900;
    run_txn("pay_10y", 24'h001000, 10, 0, -1, 1'b0, 24'h000000);
    pin_en  = 1'b0;
    run_txn("zero", 24'h000000, 0, 0, 2, 1'b0, 24'h000000);
    run_txn("resid_3j", 24'h000030, 0, 0, 2, 1'b1, 24'h000030);
    run_txn("invalid_jiao", 24'h0000A0, 0, 0, 2, 1'b1, 24'h0000A0);
    run_txn("invalid_tens", 24'h00B000, 0, 0, 2, 1'b1, 24'h00B000);
    run_txn("ignored_bits", 24'hFF005F, 0, 1, -1, 1'b0, 24'h000000);
    run_txn("resid_7j", 24'h000170, 1, 1, -1, 1'b1, 24'h000020);

    // A start while busy must not disturb the payout in progress.
    launch(24'h000200);
    lat = 0;
    while (!bus.req_1y && lat < 100) begin @(negedge CLK); #1; lat++; end
    bus.balance_in = 24'h000990;
    bus.start      = 1'b1;
    @(negedge CLK);
    #1;
    bus.start = 1'b0;
    wait_done(4000, lat);
    chk("stray_done_seen", bus.done, 1);
    chk("stray_n_1y", seen1, 2);
    chk("stray_remain", bus.remain, 24'h000000);

    // Reset during the second coin abandons the payout immediately.
    launch(24'h000500);
    lat = 0;
    while (!(seen1 == 1 && bus.req_1y) && lat < 200) begin @(negedge CLK); #1; lat++; end
    chk("rst_mid_second_req", bus.req_1y, 1);
    chk("rst_mid_first_paid", seen1, 1);
    #2;
    RSTn = 1'b0;
    #1;
    chk("rst_async_req_1y", bus.req_1y, 0);
    chk("rst_async_busy", bus.busy, 0);
    chk("rst_async_err", bus.err, 0);
    chk("rst_async_remain", bus.remain, 24'h000000);
    @(negedge CLK);
    #1;
    RSTn = 1'b1;
    run_txn("after_rst", 24'h000150, 1, 1, -1, 1'b0, 24'h000000);

`ifdef CHANGE_TIMEOUT_EN
    ack_en   = 1'b0;
    tmo_mode = 1'b1;
    run_txn("timeout", 24'h000100, 0, 0, 11, 1'b1, 24'h000100);
    tmo_mode = 1'b0;
    ack_en   = 1'b1;
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/change_dispense_module.md
CHANGE_DISPENSE_MODULE -- requirements
Module: change_dispense_module

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16'd50000, sets the number of CLK cycles to wait for coin_ack before an error is flagged.
REQ-002 CLK  input  1  system clock; all state changes on its rising edge.
REQ-003 RSTn  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  one-cycle request to pay out balance_in.
REQ-005 balance_in  input  24  BCD balance: [15:12] tens of yuan, [11:8] yuan, [7:4] jiao; bits [23:16] and [3:0] are ignored.
REQ-006 coin_ack  input  1  dispenser acknowledge, level, held high until the request drops.
REQ-007 req_1y  output  1  request one 1-yuan coin.
REQ-008 req_5j  output  1  request one 5-jiao coin.
REQ-009 busy  output  1  high from the cycle after start is accepted until the cycle done pulses.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 err  output  1  sticky error flag; cleared by the next accepted start.
REQ-012 remain  output  24  BCD amount not yet dispensed; bits [23:16] and [3:0] always 0.

Function
REQ-013 States SHALL be IDLE, CHECK, REQ, WAIT_ACK, WAIT_REL, FIN, ERR.
REQ-014 In IDLE, start=1 SHALL latch balance_in[15:4] into remain, clear err, set busy, and go to CHECK on the next edge.
REQ-015 start SHALL be ignored in every state other than IDLE.
REQ-016 CHECK, invalid BCD (any digit >9): go to ERR with no coin request.
REQ-017 CHECK, tens or yuan digit non-zero: select 1-yuan and go to REQ.
REQ-018 CHECK, otherwise jiao >=5: select 5-jiao and go to REQ.
REQ-019 CHECK, otherwise jiao 0: go to FIN.
REQ-020 CHECK, otherwise jiao 1..4: set err and go to FIN with the residual left in remain.
REQ-021 REQ SHALL assert the selected req_* registered, so it rises one cycle after CHECK, and SHALL go to WAIT_ACK.
REQ-022 In WAIT_ACK, coin_ack=1 SHALL drop req_*, decrement remain by the coin value, and go to WAIT_REL.
REQ-023 1-yuan decrement SHALL borrow in BCD: yuan 0 becomes 9 and tens decrements.
REQ-024 5-jiao decrement SHALL subtract 5 from the jiao digit.
REQ-025 WAIT_REL SHALL wait for coin_ack=0, then return to CHECK.
REQ-026 req_1y and req_5j SHALL never be high together.
REQ-027 FIN SHALL pulse done for one cycle, drop busy, and return to IDLE.
REQ-028 ERR SHALL set err, drop all req_*, pulse done, and return to IDLE.
REQ-029 In all cases remain SHALL hold the undispensed amount.
REQ-030 A zero balance SHALL reach done 2 cycles after start with no request.

Reset
REQ-031 RSTn low SHALL immediately force IDLE, req_1y=0, req_5j=0, busy=0, done=0, err=0 and remain=0, including mid-payout; a partially dispensed payout is abandoned.

Configuration
REQ-032 With CHANGE_TIMEOUT_EN defined, a counter SHALL run in WAIT_ACK and WAIT_REL.
REQ-033 The counter SHALL restart on each state entry.
REQ-034 Reaching ACK_TIMEOUT SHALL go to ERR with remain not decremented for the pending coin.
REQ-035 With CHANGE_TIMEOUT_EN undefined, the block SHALL wait indefinitely and no counter logic SHALL exist.

Structure
REQ-036 A shared package SHALL hold the state encoding, the BCD digit width (4), the coin value constants (1-yuan, 5-jiao), and the balance field bit positions, for reuse by the coin-accumulation logic.
REQ-037 Sub-module change_ack_timer SHALL hold the timeout counter and be instantiated only under CHANGE_TIMEOUT_EN.

Verification
REQ-038 Balance 12.5 yuan: balance_in=24'h001250, ack each req after 3 cycles -> 12 req_1y handshakes then 1 req_5j, done, err=0, remain=0.
REQ-039 Balance 10 yuan: balance_in=24'h001000 -> yuan borrow to 9 after the first coin, 10 req_1y handshakes, remain=0.
REQ-040 Residual jiao: balance_in=24'h000030 -> no req, done after 2 cycles, err=1, remain=24'h000030.
REQ-041 Invalid BCD: balance_in=24'h0000A0 -> ERR, no req, err=1, done pulse.
REQ-042 Timeout: CHANGE_TIMEOUT_EN defined, ACK_TIMEOUT=8, balance 24'h000100, coin_ack tied 0 -> req_1y drops, err=1, remain=24'h000100.
REQ-043 Reset mid-payout: RSTn asserted during the second coin of 24'h000500 -> all outputs 0 at once; a later start behaves normally.
